// File: rtl/maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maze_mem_arbiter
// Description : Two-port front end for the maze memory. Arbitrates game-logic
//               port A (read/write) and display port B (read-only), sequences
//               each access and owns the bidirectional memory data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_mem_arbiter #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic              a_rvalid,
    output logic              a_wack,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rvalid,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_command,
    inout  wire  [WIDTH-1:0]  mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_b;
    logic              w_last_b_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_port_b;
    logic              w_port_b_nxt;
    logic              r_drive;
    logic              w_drive_nxt;
    logic [WIDTH-1:0]  r_wdata;
    logic [WIDTH-1:0]  w_wdata_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_cmd_nxt;
    logic [WIDTH-1:0]  w_rdata_nxt;
    logic              w_a_rvalid_nxt;
    logic              w_a_wack_nxt;
    logic              w_b_rvalid_nxt;
    logic              w_grant_a;
    logic              w_grant_b;

    // On contention the port that did not win last time gets the bus.
    assign w_grant_a = a_valid && (!b_valid || r_last_b);
    assign w_grant_b = b_valid && !w_grant_a;

    assign a_ready = rst_n && (r_state == ST_IDLE) && w_grant_a;
    assign b_ready = rst_n && (r_state == ST_IDLE) && w_grant_b;

    // Driver enable and mem_command flip on the same edge, so the memory and
    // this block never drive the bus together.
    assign mem_data = r_drive ? r_wdata : {WIDTH{1'bz}};

    always_comb begin
        w_state_nxt    = r_state;
        w_last_b_nxt   = r_last_b;
        w_we_nxt       = r_we;
        w_port_b_nxt   = r_port_b;
        w_wdata_nxt    = r_wdata;
        w_addr_nxt     = mem_address;
        w_cmd_nxt      = 1'b1;
        w_drive_nxt    = 1'b0;
        w_rdata_nxt    = rdata;
        w_a_rvalid_nxt = 1'b0;
        w_a_wack_nxt   = 1'b0;
        w_b_rvalid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_a) begin
                    w_we_nxt     = a_we;
                    w_port_b_nxt = 1'b0;
                    w_addr_nxt   = a_addr;
                    w_wdata_nxt  = a_wdata;
                    w_last_b_nxt = 1'b0;
                    w_cmd_nxt    = !a_we;
                    w_drive_nxt  = a_we;
                    w_state_nxt  = ST_ACCESS;
                end else if (w_grant_b) begin
                    w_we_nxt     = 1'b0;
                    w_port_b_nxt = 1'b1;
                    w_addr_nxt   = b_addr;
                    w_last_b_nxt = 1'b1;
                    w_state_nxt  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_a_wack_nxt = 1'b1;
                    w_state_nxt  = ST_TURN;
                end else begin
                    w_rdata_nxt    = mem_data;
                    w_a_rvalid_nxt = !r_port_b;
                    w_b_rvalid_nxt = r_port_b;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_b    <= 1'b1;
            r_we        <= 1'b0;
            r_port_b    <= 1'b0;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
            mem_address <= '0;
            mem_command <= 1'b1;
            rdata       <= '0;
            a_rvalid    <= 1'b0;
            a_wack      <= 1'b0;
            b_rvalid    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_b    <= w_last_b_nxt;
            r_we        <= w_we_nxt;
            r_port_b    <= w_port_b_nxt;
            r_drive     <= w_drive_nxt;
            r_wdata     <= w_wdata_nxt;
            mem_address <= w_addr_nxt;
            mem_command <= w_cmd_nxt;
            rdata       <= w_rdata_nxt;
            a_rvalid    <= w_a_rvalid_nxt;
            a_wack      <= w_a_wack_nxt;
            b_rvalid    <= w_b_rvalid_nxt;
        end
    end

endmodule
`default_nettype wire
